clkinv_div_bank: RTL

- Parametrised multi-channel clock divider with per-channel selectable output inversion.
- Each channel generates two registered outputs from one master clock:
  - a one-cycle enable pulse every R cycles;
  - a near-50% divided square wave.
- Ratios are reprogrammed glitch-free through a valid/ready write port.
- Sits beside the clock-tree inverter cells and feeds divided enables to clock gates in low-speed domains.

---
 rtl/clkinv_div_pkg.sv | 20 ++
 rtl/clkinv_div_chan.sv | 96 +++++++++
 rtl/clkinv_div_bank.sv | 74 +++++++
 3 files changed

// File: rtl/clkinv_div_pkg.sv
// clkinv_div_pkg
// Shared types and helpers for the clkinv_div_bank divider bank.
//   RATIO_W   : default ratio width used by ratio_t
//   ratio_t   : divide ratio R (0 = channel off)
//   RATIO_OFF : ratio value that switches a channel off
//   ceil_half : ceil(r/2), the high-phase length of the square wave
package clkinv_div_pkg;

  parameter int RATIO_W = 8;

  typedef logic [RATIO_W-1:0] ratio_t;

  localparam int RATIO_OFF = 0;

  // Operates on 16 bits so any channel width up to 16 can zero-extend into it.
  function automatic logic [15:0] ceil_half(input logic [15:0] r);
    return (r >> 1) + {15'd0, r[0]};
  endfunction

endpackage

// File: rtl/clkinv_div_chan.sv
// clkinv_div_chan
// One divider channel: active ratio, shadow ratio, pending flag, counter and
// the registered EN / ZN outputs.
// Optional feature macro: CLKINV_DIV_PHASE_ALIGN_EN (enables the sync input).
// Ports:
//   clk, rst : master clock, synchronous active-high reset
//   wr       : accepted write for this channel (only asserted while !pend)
//   wdata    : new ratio loaded into the shadow register
//   sync     : phase-align strobe
//   pend     : shadow ratio waiting for the next update point
//   en       : one-cycle pulse following the last count of each period
//   zn       : divided square wave, XORed with INV
module clkinv_div_chan
  import clkinv_div_pkg::*;
#(
  parameter int W   = 8,
  parameter bit INV = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         sync,
  output logic         pend,
  output logic         en,
  output logic         zn
);

  logic [W-1:0] ra;
  logic [W-1:0] rs;
  logic [W-1:0] cnt;
  logic         p;
  logic         last;
  logic         upd;
  logic         q_next;
  logic         sync_eff;
  logic [15:0]  half;

`ifdef CLKINV_DIV_PHASE_ALIGN_EN
  assign sync_eff = sync;
`else
  // Phase alignment is not built in: the strobe is accepted and dropped.
  wire unused_sync = sync;
  assign sync_eff = 1'b0;
`endif

  assign pend = p;

  always_comb begin
    last   = (ra != W'(RATIO_OFF)) && (cnt == ra - W'(1));
    // Shadow ratio is taken over only at a period boundary, or immediately
    // when the channel is off, so no runt period can ever be produced.
    upd    = p && ((ra == W'(RATIO_OFF)) || last);
    half   = ceil_half(16'(ra));
    q_next = (16'(cnt) < half);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra  <= '0;
      rs  <= '0;
      cnt <= '0;
      p   <= 1'b0;
      en  <= 1'b0;
      zn  <= INV;
    end else begin
      en <= last;
      zn <= q_next ^ INV;
      if (sync_eff) begin
        // Sync applies any pending ratio and restarts the period; a write in
        // the same cycle is still taken and re-arms the pending flag.
        if (p) ra <= rs;
        cnt <= '0;
        p   <= wr;
        if (wr) rs <= wdata;
      end else begin
        if (upd) begin
          ra  <= rs;
          p   <= 1'b0;
          cnt <= '0;
        end else if (last) begin
          cnt <= '0;
        end else if (ra != W'(RATIO_OFF)) begin
          cnt <= cnt + W'(1);
        end
        // wr is only ever asserted while p is clear, so it cannot collide
        // with an update of this channel.
        if (wr) begin
          rs <= wdata;
          p  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clkinv_div_bank.sv
// clkinv_div_bank
// Multi-channel clock divider with per-channel output inversion and a
// glitch-free valid/ready ratio write port.
// Optional feature macro: CLKINV_DIV_PHASE_ALIGN_EN (SYNC phase alignment).
// Handshake: a write transfers on a CLK edge where W_VALID and W_READY are
// both high; W_READY is low only while the selected channel still holds a
// pending ratio. W_VALID may be held across stall cycles.
// Ports:
//   CLK, RST  : master clock, synchronous active-high reset
//   W_VALID   : ratio write request
//   W_READY   : write can be accepted for the channel on W_SEL
//   W_SEL     : target channel (values >= NCH accepted with no effect)
//   W_DATA    : new ratio R (0 = channel off)
//   SYNC      : phase-align strobe
//   EN        : per-channel enable pulses
//   ZN        : per-channel square waves, polarity from INV_MASK
//   VDD, VSS  : supply pins, no logic function
module clkinv_div_bank
  import clkinv_div_pkg::*;
#(
  parameter int             NCH      = 4,
  parameter int             W        = 8,
  parameter logic [NCH-1:0] INV_MASK = {NCH{1'b1}},
  localparam int            SW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            W_VALID,
  output logic            W_READY,
  input  logic [SW-1:0]   W_SEL,
  input  logic [W-1:0]    W_DATA,
  input  logic            SYNC,
  output logic [NCH-1:0]  EN,
  output logic [NCH-1:0]  ZN,
  inout  wire             VDD,
  inout  wire             VSS
);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] wr;

  wire unused_supply = &{1'b0, VDD, VSS};

  always_comb begin
    W_READY = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (int'(W_SEL) == i) W_READY = !pend[i];
    end
  end

  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = W_VALID && W_READY && (int'(W_SEL) == i);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clkinv_div_chan #(
      .W   (W),
      .INV (INV_MASK[g])
    ) u_chan (
      .clk   (CLK),
      .rst   (RST),
      .wr    (wr[g]),
      .wdata (W_DATA),
      .sync  (SYNC),
      .pend  (pend[g]),
      .en    (EN[g]),
      .zn    (ZN[g])
    );
  end

endmodule
